// File: rtl/lshift_sat_rescale_16b.sv
// lshift_sat_rescale_16b
//   Restores FFT output magnitude after per-stage right-shift scaling. Each
//   sample of a 16-bit signed stream is arithmetically left-shifted by a
//   per-frame amount (0..MAX_SHIFT). Overflowing samples are counted per
//   FRAME_LEN-sample frame. The data path is a one-deep registered
//   valid/ready stage with 1-cycle latency.
//
//   Build option LSHIFT_SAT_EN:
//     defined   - overflowing samples clamp to 16'h7FFF / 16'h8000
//     undefined - overflowing samples wrap (low 16 bits of the shift);
//                 they are still counted
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high
//   data_in[15:0]    in   signed input sample
//   in_valid         in   data_in is valid
//   in_ready         out  block accepts data_in this cycle
//   shift_amt[2:0]   in   shift amount, sampled on the first sample of a frame
//   data_out[15:0]   out  rescaled signed sample
//   out_valid        out  data_out is valid
//   out_ready        in   consumer accepts data_out
//   out_last         out  data_out is the last sample of its frame
//   frame_sat_count  out  overflow count of the last completed frame
//   frame_done       out  1-cycle pulse after the last sample is accepted downstream

module lshift_sat_rescale_16b #(
   parameter int FRAME_LEN = 64,
   parameter int MAX_SHIFT = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  shift_amt,
   output logic [15:0] data_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic [6:0]  frame_sat_count,
   output logic        frame_done
);

   localparam int            CW       = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
   localparam logic [2:0]    MAX_SH   = 3'(MAX_SHIFT);

   // The frame state is carried entirely by the sample counter: index 0 means
   // no frame is open, anything else means a frame is in progress.
   typedef enum logic {IDLE, RUN} phase_t;

   phase_t               phase;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [6:0]           run_q, run_d;
   logic [2:0]           shift_q, shift_d, cur_shift;
   logic [15:0]          shifted, y;
   logic signed [15:0]   back;
   logic                 ovf, in_xfer, out_xfer;

   assign in_ready = ~out_valid | out_ready;
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      phase   = (cnt_q == '0) ? IDLE : RUN;
      cnt_d   = cnt_q;
      run_d   = run_q;
      shift_d = shift_q;

      // First sample of a frame uses the live (clamped) shift input; the rest
      // of the frame uses the value latched with that first sample.
      cur_shift = shift_q;
      if (phase == IDLE)
         cur_shift = (shift_amt > MAX_SH) ? MAX_SH : shift_amt;

      // Overflow iff shifting back does not recover the input, i.e. the bits
      // shifted out differ from the resulting sign bit.
      shifted = data_in << cur_shift;
      back    = $signed(shifted) >>> cur_shift;
      ovf     = (back != $signed(data_in));

      y = shifted;
`ifdef LSHIFT_SAT_EN
      if (ovf)
         y = data_in[15] ? 16'h8000 : 16'h7FFF;
`endif

      if (in_xfer) begin
         shift_d = cur_shift;
         cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
         // The running count restarts with the first sample of each frame.
         run_d   = ((phase == IDLE) ? 7'd0 : run_q) + {6'd0, ovf};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q           <= '0;
         run_q           <= '0;
         shift_q         <= '0;
         data_out        <= '0;
         out_valid       <= 1'b0;
         out_last        <= 1'b0;
         frame_sat_count <= '0;
         frame_done      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         run_q      <= run_d;
         shift_q    <= shift_d;
         frame_done <= out_xfer & out_last;

         // The last sample left the input side at least one cycle ago, so
         // run_q already includes it even if the next frame starts now.
         if (out_xfer & out_last)
            frame_sat_count <= run_q;

         if (in_xfer) begin
            data_out  <= y;
            out_last  <= (cnt_q == LAST_IDX);
            out_valid <= 1'b1;
         end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lshift_sat_rescale_16b.sv
// Self-checking bench for lshift_sat_rescale_16b: directed vector tables,
// hand-written multi-cycle sequences and randomized traffic compared against
// an arithmetic reference model. Expectations follow LSHIFT_SAT_EN.

module tb_lshift_sat_rescale_16b;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  shift_amt;
   logic [15:0] data_out;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [6:0]  frame_sat_count;
   logic        frame_done;

   always #5 clk = ~clk;

   lshift_sat_rescale_16b dut (
      .clock           (clk),
      .reset           (reset),
      .data_in         (data_in),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .shift_amt       (shift_amt),
      .data_out        (data_out),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_last        (out_last),
      .frame_sat_count (frame_sat_count),
      .frame_done      (frame_done)
   );

   typedef struct {
      logic [15:0] data;
      logic        last;
      int          cnt;
   } exp_t;

   typedef struct {
      int          frame;
      int          pos;
      logic [15:0] din;
      logic [2:0]  sh;
      logic [15:0] expv;
   } vec_t;

   exp_t        exp_q[$];
   logic [15:0] got_q[$];
   int          fsc_q[$];

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   int m_idx   = 0;
   int m_shift = 0;
   int m_run   = 0;

   // monitor state
   exp_t        mon_e;
   bit          exp_done   = 1'b0;
   int          exp_fsc    = 0;
   bit          prev_in    = 1'b0;
   bit          prev_stall = 1'b0;
   logic [15:0] stall_data;
   logic        stall_last;
   int          done_pulses = 0;
   int          bubbles     = 0;

   // driver state
   bit rand_bp = 1'b0;
   int stall   = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   // Model: value * 2^shift in plain integer arithmetic, then clamp or wrap.
   task automatic model_accept(input logic [15:0] d, input logic [2:0] sh);
      int         p;
      bit         ov;
      logic [31:0] pv;
      exp_t       e;
      if (m_idx == 0) begin
         m_shift = (sh > 3'd6) ? 6 : int'(sh);
         m_run   = 0;
      end
      p  = $signed(d) * (1 << m_shift);
      ov = (p > 32767) || (p < -32768);
      pv = p;
      e.data = pv[15:0];
`ifdef LSHIFT_SAT_EN
      if (ov) e.data = (p < 0) ? 16'h8000 : 16'h7FFF;
`endif
      if (ov) m_run++;
      e.last = (m_idx == 63);
      e.cnt  = m_run;
      exp_q.push_back(e);
      m_idx = (m_idx + 1) % 64;
   endtask

   // Monitor samples mid-cycle; a transfer seen here happens on the next rising edge.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_idx      = 0;
         m_run      = 0;
         exp_done   = 1'b0;
         prev_in    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("in_ready", in_ready, !out_valid || out_ready);
         if (prev_in) check("latency_valid", out_valid, 1'b1);
         if (prev_stall) begin
            check("hold_data", data_out, stall_data);
            check("hold_last", out_last, stall_last);
         end
         check("frame_done", frame_done, exp_done);
         if (frame_done) begin
            done_pulses++;
            fsc_q.push_back(int'(frame_sat_count));
            if (exp_done) check("frame_sat_count", frame_sat_count, exp_fsc);
         end
         exp_done = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               flag("unexpected_output");
            end else begin
               mon_e = exp_q.pop_front();
               check("data_out", data_out, mon_e.data);
               check("out_last", out_last, mon_e.last);
               exp_done = mon_e.last;
               exp_fsc  = mon_e.cnt;
            end
            got_q.push_back(data_out);
         end
         prev_stall = out_valid && !out_ready;
         stall_data = data_out;
         stall_last = out_last;
         if (in_valid && !in_ready) bubbles++;
         prev_in = in_valid && in_ready;
         if (prev_in) model_accept(data_in, shift_amt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      if (stall > 0) begin
         out_ready = 1'b0;
         stall--;
      end else begin
         out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic send(input logic [15:0] d, input logic [2:0] sh);
      bit ok;
      ok        = 1'b0;
      in_valid  = 1'b1;
      data_in   = d;
      shift_amt = sh;
      for (int w = 0; w < 200; w++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         tick();
         if (ok) break;
      end
      in_valid = 1'b0;
      if (!ok) flag("send_timeout");
   endtask

   task automatic drain(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      @(negedge clk);
      check("rst_data_out", data_out, 16'h0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_frame_sat_count", frame_sat_count, 7'd0);
      check("rst_frame_done", frame_done, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   task automatic check_got(input string name, input int idx, input logic [15:0] expv);
      if (idx >= got_q.size()) flag({name, "_missing"});
      else check(name, got_q[idx], expv);
   endtask

   task automatic check_fsc(input string name, input int idx, input int expv);
      if (idx >= fsc_q.size()) flag({name, "_missing"});
      else check(name, fsc_q[idx], expv);
   endtask

   vec_t tv[8];

   initial begin
      int base, nd, nf, nb, found;
      logic [15:0] d;

`ifdef LSHIFT_SAT_EN
      tv[0] = '{0, 0,  16'h2000, 3'd2, 16'h7FFF};
      tv[3] = '{0, 3,  16'hDFFF, 3'd2, 16'h8000};
      tv[5] = '{1, 1,  16'h0200, 3'd7, 16'h7FFF};
`else
      tv[0] = '{0, 0,  16'h2000, 3'd2, 16'h8000};
      tv[3] = '{0, 3,  16'hDFFF, 3'd2, 16'h7FFC};
      tv[5] = '{1, 1,  16'h0200, 3'd7, 16'h8000};
`endif
      tv[1] = '{0, 1,  16'hE000, 3'd2, 16'h8000};
      tv[2] = '{0, 2,  16'h1FFF, 3'd2, 16'h7FFC};
      tv[4] = '{1, 0,  16'h0001, 3'd7, 16'h0040};
      tv[6] = '{1, 10, 16'h0003, 3'd0, 16'h00C0};
      tv[7] = '{1, 11, 16'hFFFF, 3'd0, 16'hFFC0};

      reset     = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      shift_amt = '0;
      out_ready = 1'b1;

      do_reset();

      // Full frame of 0x0100 at shift 6
      base = got_q.size(); nd = done_pulses; nf = fsc_q.size();
      for (int i = 0; i < 64; i++) send(16'h0100, 3'd6);
      drain(4);
      for (int i = 0; i < 64; i++) check_got("t1_data", base + i, 16'h4000);
      check("t1_done_count", done_pulses - nd, 1);
      check_fsc("t1_fsc", nf, 0);

      // Directed vector table: overflow/wrap cases, shift clamp, mid-frame shift change
      base = got_q.size(); nf = fsc_q.size();
      for (int f = 0; f < 2; f++) begin
         for (int p = 0; p < 64; p++) begin
            found = -1;
            for (int k = 0; k < 8; k++)
               if (tv[k].frame == f && tv[k].pos == p) found = k;
            if (found >= 0) send(tv[found].din, tv[found].sh);
            else send(16'h0000, 3'd0);
         end
      end
      drain(4);
      for (int k = 0; k < 8; k++)
         check_got("table_data", base + tv[k].frame * 64 + tv[k].pos, tv[k].expv);
      check_fsc("table_fsc_f0", nf, 2);
      check_fsc("table_fsc_f1", nf + 1, 1);

      // Backpressure: 5-cycle stall mid-frame
      base = got_q.size(); nb = bubbles;
      for (int i = 0; i < 64; i++) begin
         if (i == 20) stall = 5;
         send(16'(i), 3'd3);
      end
      drain(4);
      check("bp_stall_cycles", bubbles - nb, 5);
      check("bp_count", got_q.size() - base, 64);
      for (int i = 0; i < 64; i++) check_got("bp_order", base + i, 16'(i * 8));

      // Back-to-back frames, no bubble at the boundary, independent counts
      nb = bubbles; nd = done_pulses; nf = fsc_q.size();
      for (int i = 0; i < 128; i++) begin
         d = (i < 8) ? 16'h4000 : 16'(i);
         send(d, 3'd1);
      end
      drain(4);
      check("b2b_bubbles", bubbles - nb, 0);
      check("b2b_done_count", done_pulses - nd, 2);
      check_fsc("b2b_fsc_f1", nf, 8);
      check_fsc("b2b_fsc_f2", nf + 1, 0);

      // Reset at sample 30: frame aborted, no frame_done, next frame fresh
      nd = done_pulses;
      for (int i = 0; i < 30; i++) send(16'h3000, 3'd2);
      do_reset();
      drain(4);
      check("rst_no_done", done_pulses - nd, 0);
      base = got_q.size(); nf = fsc_q.size();
      for (int i = 0; i < 64; i++) send(16'h0001, 3'd5);
      drain(4);
      check_got("post_rst_first", base, 16'h0020);
      check_got("post_rst_last", base + 63, 16'h0020);
      check("post_rst_done", done_pulses - nd, 1);
      check_fsc("post_rst_fsc", nf, 0);

      // Randomized traffic with random backpressure against the model
      rand_bp = 1'b1;
      for (int i = 0; i < 64 * 4; i++) begin
         case ($urandom_range(0, 3))
            0:       d = 16'h7FFF;
            1:       d = 16'h8000;
            default: d = 16'($urandom);
         endcase
         send(d, 3'($urandom_range(0, 7)));
      end
      rand_bp = 1'b0;
      drain(10);
      check("model_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
